// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a shared-ALU, shared-memory RV32I datapath.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       adr_src,
  output logic       ir_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_we,
  output logic [1:0] res_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7, ALUWB = 4'd8,
    BRANCH = 4'd9, JAL = 4'd10, JALR_ADR = 4'd11, JALR = 4'd12, LUI = 4'd13,
    AUIPC = 4'd14, ILLEGAL = 4'd15;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
    SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd4;
  logic [3:0] cur, nxt, rtype_alu;
  logic taken, br_bad, r_bad, i_bad;
  assign state = cur;
  assign taken = zero ^ funct3[0] ^ funct3[2];
  assign br_bad = funct3[2:1] == 2'b01;
  assign r_bad = funct7_5 && funct3 != 3'b000 && funct3 != 3'b101;
  assign i_bad = funct7_5 && funct3 == 3'b001;
  // op[5] separates R-type from I-type, so SUB is only possible for R-type
  always_comb
    case (funct3)
      3'b000: rtype_alu = (funct7_5 && op[5]) ? SUB : ADD;
      3'b001: rtype_alu = SLL;
      3'b010: rtype_alu = SLT;
      3'b011: rtype_alu = SLTU;
      3'b100: rtype_alu = XOR_;
      3'b101: rtype_alu = funct7_5 ? SRA : SRL;
      3'b110: rtype_alu = OR_;
      default: rtype_alu = AND_;
    endcase
  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= RESET_STATE;
    else cur <= nxt;
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH: nxt = mem_ready ? DECODE : FETCH;
      DECODE:
        case (op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011: nxt = EXEC_R;
          7'b0010011: nxt = EXEC_I;
          7'b1100011: nxt = BRANCH;
          7'b1101111: nxt = JAL;
          7'b1100111: nxt = JALR_ADR;
          7'b0110111: nxt = LUI;
          7'b0010111: nxt = AUIPC;
          default: nxt = ILLEGAL;
        endcase
      MEMADR: nxt = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD: nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB: nxt = FETCH;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      EXEC_R: nxt = r_bad ? ILLEGAL : ALUWB;
      EXEC_I: nxt = i_bad ? ILLEGAL : ALUWB;
      ALUWB: nxt = FETCH;
      BRANCH: nxt = br_bad ? ILLEGAL : FETCH;
      JAL, JALR, LUI, AUIPC: nxt = ALUWB;
      JALR_ADR: nxt = JALR;
      default: nxt = ILLEGAL;
    endcase
  end
  always_comb begin
    pc_we = 1'b0;
    adr_src = 1'b0;
    ir_we = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    reg_we = 1'b0;
    res_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_ctrl = ADD;
    imm_src = IMM_I;
    illegal = 1'b0;
    if (!rst)
      case (cur)
        FETCH: begin
          mem_re = 1'b1;
          alu_src_b = 2'b10;
          res_src = 2'b10;
          ir_we = mem_ready;
          pc_we = mem_ready;
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src = IMM_B;
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src = op[5] ? IMM_S : IMM_I;
        end
        MEMREAD: begin
          adr_src = 1'b1;
          mem_re = 1'b1;
        end
        MEMWB: begin
          res_src = 2'b01;
          reg_we = 1'b1;
        end
        MEMWRITE: begin
          adr_src = 1'b1;
          mem_we = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 2'b10;
          alu_ctrl = rtype_alu;
        end
        EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_ctrl = rtype_alu;
        end
        ALUWB: reg_we = 1'b1;
        BRANCH: begin
          alu_src_a = 2'b10;
          if (!br_bad) begin
            alu_ctrl = funct3[2] ? (funct3[1] ? SLTU : SLT) : SUB;
            pc_we = taken;
          end
        end
        JAL, JALR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_we = 1'b1;
        end
        JALR_ADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
          imm_src = IMM_U;
        end
        AUIPC: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src = IMM_U;
        end
        default: illegal = 1'b1;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle vector table with a scoreboard queue for multicycle_ctrl.
module tb_multicycle_ctrl;
  typedef struct packed {
    logic [3:0] st;
    logic pc_we, adr_src, ir_we, mem_re, mem_we, reg_we;
    logic [1:0] res, a, b;
    logic [3:0] alu;
    logic [2:0] imm;
    logic ill;
  } outs_t;
  typedef struct {
    string name;
    logic r;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z, mr;
    outs_t exp;
  } vec_t;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011,
    BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;
  logic clk = 0, rst = 1, funct7_5 = 0, zero = 0, mem_ready = 1;
  logic [6:0] op = 0;
  logic [2:0] funct3 = 0;
  logic pc_we, adr_src, ir_we, mem_re, mem_we, reg_we, illegal;
  logic [1:0] res_src, alu_src_a, alu_src_b;
  logic [3:0] alu_ctrl, state;
  logic [2:0] imm_src;
  outs_t act;
  vec_t vecs[$];
  outs_t sb[$];
  int n_cmp = 0, n_bad = 0;
  outs_t O_RST, O_F, O_FW, O_D, O_MAL, O_MAS, O_MR, O_MWB, O_MW, O_WB, O_JAL, O_JA, O_JR,
    O_LUI, O_AUI, O_ILL;
  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .adr_src(adr_src), .ir_we(ir_we), .mem_re(mem_re),
    .mem_we(mem_we), .reg_we(reg_we), .res_src(res_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src), .illegal(illegal),
    .state(state)
  );
  assign act = {state, pc_we, adr_src, ir_we, mem_re, mem_we, reg_we, res_src, alu_src_a,
                alu_src_b, alu_ctrl, imm_src, illegal};
  always #5 clk = ~clk;
  function automatic outs_t o(logic [3:0] st, logic [5:0] en, logic [1:0] res, logic [1:0] a,
                              logic [1:0] b, logic [3:0] alu, logic [2:0] imm, logic ill);
    return {st, en, res, a, b, alu, imm, ill};
  endfunction
  function automatic void add(string n, logic r, logic [6:0] p, logic [2:0] f3, logic f7,
                              logic z, logic mr, outs_t e);
    vec_t v;
    v.name = n; v.r = r; v.op = p; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endfunction
  task automatic chk(string n, outs_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, e, $time);
    end
  endtask
  task automatic add_ins(string n, logic [6:0] p, logic [2:0] f3, logic f7, logic z,
                         outs_t e2, outs_t e3);
    add({n, "_f"}, 0, p, f3, f7, z, 1, O_F);
    add({n, "_d"}, 0, p, f3, f7, z, 1, O_D);
    add({n, "_x"}, 0, p, f3, f7, z, 1, e2);
    if (e3.st != 0) add({n, "_w"}, 0, p, f3, f7, z, 1, e3);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    O_RST = o(0, 6'b000000, 0, 0, 0, 0, 0, 0);
    O_F   = o(0, 6'b101100, 2, 0, 2, 0, 0, 0);
    O_FW  = o(0, 6'b000100, 2, 0, 2, 0, 0, 0);
    O_D   = o(1, 6'b000000, 0, 1, 1, 0, 2, 0);
    O_MAL = o(2, 6'b000000, 0, 2, 1, 0, 0, 0);
    O_MAS = o(2, 6'b000000, 0, 2, 1, 0, 1, 0);
    O_MR  = o(3, 6'b010100, 0, 0, 0, 0, 0, 0);
    O_MWB = o(4, 6'b000001, 1, 0, 0, 0, 0, 0);
    O_MW  = o(5, 6'b010010, 0, 0, 0, 0, 0, 0);
    O_WB  = o(8, 6'b000001, 0, 0, 0, 0, 0, 0);
    O_JAL = o(10, 6'b100000, 0, 1, 2, 0, 0, 0);
    O_JA  = o(11, 6'b000000, 0, 2, 1, 0, 0, 0);
    O_JR  = o(12, 6'b100000, 0, 1, 2, 0, 0, 0);
    O_LUI = o(13, 6'b000000, 0, 3, 1, 0, 4, 0);
    O_AUI = o(14, 6'b000000, 0, 1, 1, 0, 4, 0);
    O_ILL = o(15, 6'b000000, 0, 0, 0, 0, 0, 1);
    add("reset", 1, R, 0, 0, 0, 1, O_RST);
    add_ins("add", R, 3'b000, 0, 0, o(6, 0, 0, 2, 0, 0, 0, 0), O_WB);
    add_ins("sub", R, 3'b000, 1, 0, o(6, 0, 0, 2, 0, 1, 0, 0), O_WB);
    add_ins("sra", R, 3'b101, 1, 0, o(6, 0, 0, 2, 0, 9, 0, 0), O_WB);
    add_ins("and", R, 3'b111, 0, 0, o(6, 0, 0, 2, 0, 2, 0, 0), O_WB);
    add_ins("addi_f7", I, 3'b000, 1, 0, o(7, 0, 0, 2, 1, 0, 0, 0), O_WB);
    add_ins("srai", I, 3'b101, 1, 0, o(7, 0, 0, 2, 1, 9, 0, 0), O_WB);
    add_ins("sltiu", I, 3'b011, 0, 0, o(7, 0, 0, 2, 1, 6, 0, 0), O_WB);
    add("lw_f", 0, LD, 2, 0, 0, 1, O_F);
    add("lw_d", 0, LD, 2, 0, 0, 1, O_D);
    add("lw_a", 0, LD, 2, 0, 0, 1, O_MAL);
    for (int k = 0; k < 3; k++) add("lw_rd_wait", 0, LD, 2, 0, 0, 0, O_MR);
    add("lw_rd", 0, LD, 2, 0, 0, 1, O_MR);
    add("lw_wb", 0, LD, 2, 0, 0, 1, O_MWB);
    add_ins("sw", ST, 3'b010, 0, 0, O_MAS, O_MW);
    add_ins("beq_z1", BR, 3'b000, 0, 1, o(9, 6'b100000, 0, 2, 0, 1, 0, 0), O_RST);
    add_ins("bne_z1", BR, 3'b001, 0, 1, o(9, 6'b000000, 0, 2, 0, 1, 0, 0), O_RST);
    add_ins("blt_z0", BR, 3'b100, 0, 0, o(9, 6'b100000, 0, 2, 0, 5, 0, 0), O_RST);
    add_ins("bgeu_z0", BR, 3'b111, 0, 0, o(9, 6'b000000, 0, 2, 0, 6, 0, 0), O_RST);
    add_ins("jal", JL, 3'b000, 0, 0, O_JAL, O_WB);
    add("jalr_f", 0, JR, 0, 0, 0, 1, O_F);
    add("jalr_d", 0, JR, 0, 0, 0, 1, O_D);
    add("jalr_a", 0, JR, 0, 0, 0, 1, O_JA);
    add("jalr_j", 0, JR, 0, 0, 0, 1, O_JR);
    add("jalr_w", 0, JR, 0, 0, 0, 1, O_WB);
    add_ins("lui", LU, 3'b000, 0, 0, O_LUI, O_WB);
    add_ins("auipc", AU, 3'b000, 0, 0, O_AUI, O_WB);
    add("fetch_wait", 0, R, 0, 0, 0, 0, O_FW);
    add_ins("add2", R, 3'b000, 0, 0, o(6, 0, 0, 2, 0, 0, 0, 0), O_WB);
    add("badop_f", 0, 7'h7f, 0, 0, 0, 1, O_F);
    add("badop_d", 0, 7'h7f, 0, 0, 0, 1, O_D);
    for (int k = 0; k < 10; k++) add("badop_ill", 0, 7'h7f, 0, 0, 0, 1, O_ILL);
    add("reset2", 1, R, 0, 0, 0, 1, O_RST);
    add_ins("sll_f7", R, 3'b001, 1, 0, o(6, 0, 0, 2, 0, 7, 0, 0), O_ILL);
    for (int k = 0; k < 10; k++) add("sll_f7_ill", 0, R, 1, 1, 1, 1, O_ILL);
    add("reset3", 1, BR, 0, 0, 0, 1, O_RST);
    add_ins("br010", BR, 3'b010, 0, 1, o(9, 0, 0, 2, 0, 0, 0, 0), O_ILL);
    add("reset4", 1, ST, 0, 0, 0, 1, O_RST);
    add("sw2_f", 0, ST, 2, 0, 0, 1, O_F);
    add("sw2_d", 0, ST, 2, 0, 0, 1, O_D);
    add("sw2_a", 0, ST, 2, 0, 0, 1, O_MAS);
    add("sw2_wait", 0, ST, 2, 0, 0, 0, O_MW);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].r; op = vecs[i].op; funct3 = vecs[i].f3; funct7_5 = vecs[i].f7;
      zero = vecs[i].z; mem_ready = vecs[i].mr;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      chk(vecs[i].name, sb.pop_front());
    end
    // asynchronous reset in the middle of a held write
    #1 rst = 1;
    #1 chk("async_rst_mid_write", O_RST);
    @(posedge clk);
    #1 chk("rst_held", O_RST);
    rst = 0;
    mem_ready = 1;
    @(negedge clk);
    chk("fetch_after_rst", O_F);
    @(negedge clk);
    chk("decode_after_rst", O_D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the RV32I core. It sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback states. It drives all datapath enables and muxes from one Moore-style FSM, with handshake-qualified memory states. It replaces the single-cycle decoder when the core is built with one memory port and one ALU.

Parameters:
RESET_STATE, 4'd0, FETCH encoding loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
op  in  7  instr[6:0], taken from the IR output
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory handshake; access completes in a cycle with mem_ready=1
pc_we  out  1  PC write enable
adr_src  out  1  memory address: 0=PC, 1=alu_out reg
ir_we  out  1  IR and old_pc write enable
mem_re  out  1  memory read request
mem_we  out  1  memory write request
reg_we  out  1  register file write enable
res_src  out  2  result mux: 00 alu_out reg, 01 data reg, 10 ALU direct
alu_src_a  out  2  ALU A mux: 00 PC, 01 old_pc, 10 rs1 reg, 11 zero
alu_src_b  out  2  ALU B mux: 00 rs2 reg, 01 imm, 10 constant 4
alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal  out  1  high while the FSM is in ILLEGAL
state  out  4  current state, for debug and the bench

Behaviour:
- Reset:
  - rst is asynchronous and active-high. While rst=1, state=FETCH and every output is forced to 0.
  - The first fetch request is issued in the first cycle after rst falls.
- Default values: every enable is 0 and every mux or ctrl output is 0 unless a state below sets it.
- State encodings, 0-15: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, JALR, LUI, AUIPC, ILLEGAL.
- FETCH:
  - Outputs: mem_re=1, adr_src=0, a=00, b=10, ADD, res_src=10.
  - ir_we=pc_we=mem_ready.
  - Holds while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: a=01, b=01, imm B, ADD. This precomputes the branch target into alu_out.
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR_ADR; 0110111 -> LUI; 0010111 -> AUIPC.
  - Any other op -> ILLEGAL.
- MEMADR:
  - Outputs: a=10, b=01, ADD. imm I for loads, imm S for stores.
  - Next: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src=1, mem_re=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: res_src=01, reg_we=1, then FETCH.
- MEMWRITE:
  - adr_src=1, mem_we=1.
  - mem_we stays asserted and the state holds until mem_ready, then FETCH.
- EXEC_R:
  - Outputs: a=10, b=00, then ALUWB.
  - alu_ctrl is decoded from funct3/funct7_5: 000 ADD or SUB (when f7_5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA (when f7_5=1), 110 OR, 111 AND.
  - funct7_5=1 with funct3 other than 000 or 101 -> ILLEGAL instead of ALUWB.
- EXEC_I:
  - Outputs: a=10, b=01, imm I, then ALUWB.
  - alu_ctrl follows the same table, except that 000 is always ADD.
  - funct7_5 is used only for 101.
  - funct3=001 with funct7_5=1 -> ILLEGAL.
- ALUWB: res_src=00, reg_we=1, then FETCH.
- BRANCH:
  - Outputs: a=10, b=00, res_src=00.
  - alu_ctrl: SUB for 000/001, SLT for 100/101, SLTU for 110/111.
  - Taken condition: 000 taken=zero; 001 !zero; 100/110 !zero; 101/111 zero.
  - pc_we=taken, then FETCH.
  - funct3 010/011 -> ILLEGAL with pc_we=0.
- JAL: a=01, b=10, ADD, res_src=00, pc_we=1, then ALUWB, which writes old_pc+4 to rd.
- JALR_ADR: a=10, b=01, imm I, ADD, then JALR.
- JALR: same outputs as JAL, then ALUWB. Clearing target bit 0 is done in the datapath, not here.
- LUI: a=11, b=01, imm U, ADD, then ALUWB.
- AUIPC: a=01, b=01, imm U, ADD, then ALUWB.
- ILLEGAL: illegal=1, all enables 0. The FSM stays here until rst.
- CPI with mem_ready constant 1:
  - branch 3
  - R/I/LUI/AUIPC/JAL/store 4
  - load/JALR 5
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- rst asserted in any state, including mid-handshake, returns the FSM to FETCH immediately with all outputs 0. No pending write completes.

Test Plan:
1. Assert rst mid-MEMWRITE (mem_we=1) -> same cycle mem_we=0 and state=0. After release, FETCH with mem_re=1.
2. add then sub R-type, mem_ready=1 -> states 0,1,6,8 each. alu_ctrl 0 for add and 1 for sub in EXEC_R. reg_we=1 only in ALUWB. 4 cycles per instruction.
3. lw with mem_ready low for 3 cycles in MEMREAD -> mem_re held 4 cycles, then MEMWB with res_src=01, reg_we=1. Total 8 cycles.
4. beq with zero=1, then bne with zero=1 -> pc_we=1 in BRANCH for beq, pc_we=0 for bne. Both take 3 cycles.
5. jalr -> states 0,1,11,12,8. pc_we=1 only in JALR. reg_we=1 only in ALUWB.
6. op=7'b1111111; separately R-type funct3=001 with funct7_5=1 -> ILLEGAL (state 15), illegal=1. No pc_we, reg_we or mem_we for 10 further cycles.
